// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// reset/NOP constants, instruction-field extraction macros and PC helpers.
// Imported by fetch_unit and by any decode/branch logic that inspects the IR.

`ifndef FETCH_UNIT_PKG_MACROS
`define FETCH_UNIT_PKG_MACROS
// Instruction-field extraction; the argument must be a plain 32-bit identifier.
`define RV_OPCODE(ir) ir[6:0]
`define RV_RD(ir)     ir[11:7]
`define RV_FUNCT3(ir) ir[14:12]
`define RV_RS1(ir)    ir[19:15]
`define RV_RS2(ir)    ir[24:20]
`endif

package fetch_unit_pkg;

  // Fetch FSM: IDLE nothing outstanding, WAIT response wanted,
  // KILL response outstanding but stale and must be dropped.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_KILL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  // Sequential PC step; wraps modulo 2^32 with no error.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Redirect targets are always word aligned; low bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] target);
    return {target[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues one imem request at a time, fills IF/ID.
// Latency: 1-cycle memory gives request t, response t+1, id_valid and next request t+2.
// Backpressure: a full IF/ID with id_ready=0 blocks issue and holds IF/ID stable.

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_ir
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  fetch_pc_q;

  logic         id_valid_q,    id_valid_d;
  logic [31:0]  id_pc_q,       id_pc_d;
  logic [31:0]  id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0]  id_ir_q,       id_ir_d;

  logic slot_free;
  logic capture;

  // A request may issue only when nothing is outstanding, the IF/ID slot
  // will be free at the edge, and no redirect is about to move the PC.
  always_comb begin
    slot_free = !id_valid_q || id_ready;
    imem_req  = rst && (state_q == ST_IDLE) && slot_free && !redirect;
    imem_addr = pc_q;
    capture   = (state_q == ST_WAIT) && imem_rvalid && !redirect;
  end

  // Fetch FSM and PC; a redirect overrides any issue and kills an in-flight fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
    end else if (redirect) begin
      pc_q <= align_pc(redirect_target);
      case (state_q)
        ST_WAIT, ST_KILL: state_q <= imem_rvalid ? ST_IDLE : ST_KILL;
        default:          state_q <= ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (imem_req) begin
            fetch_pc_q <= pc_q;
            pc_q       <= pc_inc(pc_q);
            state_q    <= ST_WAIT;
          end
        end
        // Responses only ever retire the outstanding request; in KILL the
        // data is simply not captured.
        ST_WAIT, ST_KILL: begin
          if (imem_rvalid) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // IF/ID next state: redirect flush beats capture, capture beats consumption.
  always_comb begin
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_ir_d       = id_ir_q;
    if (redirect) begin
      id_valid_d = 1'b0;
      id_ir_d    = NOP_INSTR;
    end else if (capture) begin
      id_valid_d    = 1'b1;
      id_pc_d       = fetch_pc_q;
      id_pc_plus4_d = pc_inc(fetch_pc_q);
      id_ir_d       = imem_rdata;
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
      id_ir_d    = NOP_INSTR;
    end
  end

  // IF/ID register; an empty slot always presents the NOP encoding.
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd4;
      id_ir_q       <= NOP_INSTR;
    end else begin
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_ir_q       <= id_ir_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_ir       = id_ir_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory
// and a transaction-level model of the fetch stage checked every cycle.
// Literal expectations from the test plan pin the model itself.

module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_ir;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_ready        (id_ready),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_pc_plus4     (id_pc_plus4),
    .id_ir           (id_ir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit allow_stray = 1'b0;
  bit stray = 1'b0;

  // Memory environment
  int          mem_lat = 1;
  bit          pend = 1'b0;
  int          left = 0;
  logic [31:0] paddr = 32'd0;

  // Fetch-stage model: next PC, one outstanding fetch (wanted or not), IF/ID.
  logic [31:0] m_pc = 32'd0, m_fpc = 32'd0, m_ipc = 32'd0, m_ir = NOP;
  bit          m_vld = 1'b0, m_busy = 1'b0, m_want = 1'b0;
  logic        e_req;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return a ^ 32'h00A0_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive memory response for this cycle, then compare outputs to the model.
  task automatic prep();
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    if (pend) begin
      left--;
      if (left == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 1'b0;
      end
    end
    if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    e_req = rst && !m_busy && (!m_vld || id_ready) && !redirect;
    if (chk_en) begin
      chk("imem_req",    {31'd0, imem_req}, {31'd0, e_req});
      chk("imem_addr",   imem_addr, m_pc);
      chk("id_valid",    {31'd0, id_valid}, {31'd0, m_vld});
      chk("id_pc",       id_pc, m_ipc);
      chk("id_pc_plus4", id_pc_plus4, m_ipc + 32'd4);
      chk("id_ir",       id_ir, m_vld ? m_ir : NOP);
      tests++;
      if (imem_rvalid && !m_busy && !allow_stray) begin
        fails++;
        $display("FAIL protocol: rvalid with no outstanding fetch at %0t", $time);
      end
    end
  endtask

  // Advance one clock edge, updating the model and the memory.
  task automatic tick();
    logic        s_req;
    logic [31:0] s_addr;
    bit          captured;
    s_req  = imem_req;
    s_addr = imem_addr;
    @(posedge clk);
    captured = 1'b0;
    if (!rst) begin
      m_pc = 32'd0; m_busy = 1'b0; m_want = 1'b0;
      m_vld = 1'b0; m_ipc = 32'd0; m_ir = NOP;
    end else if (redirect) begin
      m_pc = redirect_target & ~32'd3;
      if (m_busy) begin
        if (imem_rvalid) m_busy = 1'b0;
        else             m_want = 1'b0;
      end
      m_vld = 1'b0;
      m_ir  = NOP;
    end else begin
      if (m_busy && imem_rvalid) begin
        m_busy = 1'b0;
        if (m_want) begin
          m_vld = 1'b1; m_ipc = m_fpc; m_ir = imem_rdata; captured = 1'b1;
        end
      end else if (e_req) begin
        m_fpc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1'b1; m_want = 1'b1;
      end
      if (!captured && m_vld && id_ready) begin
        m_vld = 1'b0; m_ir = NOP;
      end
    end
    if (!rst) pend = 1'b0;
    else if (s_req) begin
      pend = 1'b1; left = mem_lat; paddr = s_addr;
    end
    @(negedge clk);
  endtask

  task automatic step();
    prep();
    tick();
  endtask

  task automatic drain();
    int n = 0;
    while (m_busy && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (m_busy) begin
      fails++;
      $display("FAIL drain: fetch still outstanding after %0d cycles", n);
    end
  endtask

  initial begin
    rst = 1'b0; redirect = 1'b0; redirect_target = 32'd0; id_ready = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    @(negedge clk);
    step();
    chk_en = 1'b1;

    // Reset state
    prep();
    chk("rst_req",   {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_ir",    id_ir, 32'h0000_0013);
    chk("rst_pc",    id_pc, 32'd0);
    chk("rst_pc4",   id_pc_plus4, 32'd4);
    tick();

    // Reset release, 1-cycle memory
    rst = 1'b1;
    prep();
    chk("t1_req",  {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'd0);
    tick();
    step();
    prep();
    chk("t1_valid", {31'd0, id_valid}, 32'd1);
    chk("t1_pc",    id_pc, 32'd0);
    chk("t1_pc4",   id_pc_plus4, 32'd4);
    chk("t1_ir",    id_ir, 32'h0050_0093);
    chk("t1_next",  imem_addr, 32'd4);
    tick();

    // Backpressure
    id_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      prep();
      chk("bp_req", {31'd0, imem_req}, 32'd0);
      chk("bp_pc",  id_pc, 32'd4);
      chk("bp_ir",  id_ir, 32'd4 ^ 32'h00A0_0013);
      tick();
    end
    id_ready = 1'b1;
    prep();
    chk("bp_resume_req",  {31'd0, imem_req}, 32'd1);
    chk("bp_resume_addr", imem_addr, 32'd8);
    tick();
    drain();

    // Redirect while WAIT, 3-cycle memory
    mem_lat = 3;
    step();
    redirect = 1'b1; redirect_target = 32'h0000_0103;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prep();
      chk("kill_req",   {31'd0, imem_req}, 32'd0);
      chk("kill_valid", {31'd0, id_valid}, 32'd0);
      tick();
    end
    prep();
    chk("kill_after_valid", {31'd0, id_valid}, 32'd0);
    chk("kill_after_req",   {31'd0, imem_req}, 32'd1);
    chk("kill_after_addr",  imem_addr, 32'h0000_0100);
    mem_lat = 1;
    tick();

    // Redirect coinciding with the response
    redirect = 1'b1; redirect_target = 32'h0000_0200;
    step();
    redirect = 1'b0;
    prep();
    chk("rr_valid", {31'd0, id_valid}, 32'd0);
    chk("rr_req",   {31'd0, imem_req}, 32'd1);
    chk("rr_addr",  imem_addr, 32'h0000_0200);
    tick();
    drain();

    // PC wrap-around
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    prep();
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    step();
    prep();
    chk("wrap_pc",   id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4",  id_pc_plus4, 32'd0);
    chk("wrap_next", imem_addr, 32'd0);
    mem_lat = 3;
    tick();

    // Reset during WAIT, then a stray response after release
    rst = 1'b0;
    step();
    prep();
    chk("mrst_valid", {31'd0, id_valid}, 32'd0);
    chk("mrst_ir",    id_ir, 32'h0000_0013);
    chk("mrst_addr",  imem_addr, 32'd0);
    chk("mrst_req",   {31'd0, imem_req}, 32'd0);
    tick();
    rst = 1'b1; stray = 1'b1; allow_stray = 1'b1;
    prep();
    chk("stray_req",  {31'd0, imem_req}, 32'd1);
    chk("stray_addr", imem_addr, 32'd0);
    tick();
    stray = 1'b0; allow_stray = 1'b0;
    for (int i = 0; i < 3; i++) step();
    prep();
    chk("post_valid", {31'd0, id_valid}, 32'd1);
    chk("post_ir",    id_ir, 32'h0050_0093);
    chk("post_pc",    id_pc, 32'd0);
    tick();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
